// File: rtl/mux_n_pkg.sv
// rtl/mux_n_pkg.sv - sizing helpers for the pipelined N:1 mux tree
package mux_n_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Tree depth; a single lane still gets one (degenerate) level.
  function automatic int num_levels(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  // Levels handled by each register slice; the last slice takes what is left.
  function automatic int levels_per_slice(input int l, input int s);
    return (l + s - 1) / s;
  endfunction

  // First tree level handled by slice k (equals l once the tree is exhausted).
  function automatic int slice_lo(input int k, input int l, input int s);
    int x;
    x = k * levels_per_slice(l, s);
    return (x > l) ? l : x;
  endfunction

  // Lanes in the lower half of the top-level split; upper half is zero padded.
  function automatic int split_size(input int l);
    return 1 << (l - 1);
  endfunction

endpackage

// File: rtl/mux_n_pipe_stage.sv
// rtl/mux_n_pipe_stage.sv - one register slice of the mux tree (optional MUX_N_PIPE_SELCHK_EN error bit)
module mux_n_pipe_stage
  import mux_n_pkg::*;
#(
  parameter int W      = 8,
  parameter int M      = 4,
  parameter int PIN    = 2,
  parameter int NLEV   = 1,
  parameter int LOFF   = 0,
  parameter int LEVELS = 1,
  parameter bit LAST   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld,
  input  logic                      din_valid,
  input  logic [PIN*W-1:0]          din,
  input  logic [M-1:0]              din_sel,
`ifdef MUX_N_PIPE_SELCHK_EN
  input  logic                      din_err,
  output logic                      err_q,
`endif
  output logic                      v_q,
  output logic [(PIN>>NLEV)*W-1:0]  dout,
  output logic [M-1:0]              sel_q
);

  localparam int POUT = PIN >> NLEV;

  logic [W-1:0]      work [PIN];
  logic [POUT*W-1:0] red;

  // Collapse this slice's 2:1 levels in place; the last slice zeroes beats whose
  // select has bits set above the tree depth (out of range beyond the padding).
  always_comb begin
    for (int i = 0; i < PIN; i++) work[i] = din[i*W +: W];
    for (int j = 0; j < NLEV; j++) begin
      for (int i = 0; i < (PIN >> (j + 1)); i++) begin
        work[i] = din_sel[LOFF + j] ? work[2*i + 1] : work[2*i];
      end
    end
    red = '0;
    for (int i = 0; i < POUT; i++) red[i*W +: W] = work[i];
    if (LAST && ((din_sel >> LEVELS) != '0)) red = '0;
  end

  // Slice register: loads a beat or a bubble whenever the downstream can take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= 1'b0;
      dout  <= '0;
      sel_q <= '0;
`ifdef MUX_N_PIPE_SELCHK_EN
      err_q <= 1'b0;
`endif
    end else if (ld) begin
      v_q   <= din_valid;
      dout  <= red;
      sel_q <= din_sel;
`ifdef MUX_N_PIPE_SELCHK_EN
      err_q <= din_err;
`endif
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - pipelined N:1 mux with valid/ready; MUX_N_PIPE_SELCHK_EN adds sel_err
module mux_n_pipe
  import mux_n_pkg::*;
#(
  parameter int N      = 9,
  parameter int W      = 8,
  parameter int M      = 4,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [M-1:0]   in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
`ifdef MUX_N_PIPE_SELCHK_EN
  output logic           sel_err,
`endif
  input  logic           out_ready
);

  localparam int L = num_levels(N);
  localparam int P = 2 * split_size(L);

  logic [P*W-1:0]    lanes;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic [M-1:0]      sel_c [STAGES+1];
`ifdef MUX_N_PIPE_SELCHK_EN
  logic              err_c [STAGES+1];
`endif

  // Pad the lane vector up to a full power-of-two tree with zero lanes.
  always_comb begin
    lanes = '0;
    lanes[N*W-1:0] = in_data;
  end

  // A single lane ignores the select entirely.
  assign sel_c[0] = (N == 1) ? '0 : in_sel;
`ifdef MUX_N_PIPE_SELCHK_EN
  assign err_c[0] = (N > 1) && (32'(in_sel) >= 32'(N));
`endif

  // Load enables: a slice loads if it is empty or the slice after it loads.
  // Built from registered valids only, so there is no combinational loop.
  always_comb begin
    ld = '0;
    ld[STAGES-1] = out_ready | ~v[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) ld[k] = ld[k+1] | ~v[k];
  end

  assign in_ready = ld[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO   = slice_lo(k, L, STAGES);
    localparam int HI   = slice_lo(k + 1, L, STAGES);
    localparam int PIN  = P >> LO;
    localparam int POUT = P >> HI;

    logic [PIN*W-1:0]  din;
    logic              din_valid;
    logic [POUT*W-1:0] dout;

    if (k == 0) begin : g_src
      assign din       = lanes;
      assign din_valid = in_valid;
    end else begin : g_chain
      assign din       = g_st[k-1].dout;
      assign din_valid = v[k-1];
    end

    mux_n_pipe_stage #(
      .W      (W),
      .M      (M),
      .PIN    (PIN),
      .NLEV   (HI - LO),
      .LOFF   (LO),
      .LEVELS (L),
      .LAST   (k == STAGES - 1)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld        (ld[k]),
      .din_valid (din_valid),
      .din       (din),
      .din_sel   (sel_c[k]),
`ifdef MUX_N_PIPE_SELCHK_EN
      .din_err   (err_c[k]),
      .err_q     (err_c[k+1]),
`endif
      .v_q       (v[k]),
      .dout      (dout),
      .sel_q     (sel_c[k+1])
    );
  end

  assign out_data  = g_st[STAGES-1].dout;
  assign out_valid = v[STAGES-1];
`ifdef MUX_N_PIPE_SELCHK_EN
  assign sel_err   = v[STAGES-1] & err_c[STAGES];
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb/tb_mux_n_pipe.sv - directed checks of mux_n_pipe in three configurations
module tb_mux_n_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [71:0]  d0;
  logic [3:0]   s0;
  logic         v0, r0, rdy0, ov0;
  logic [7:0]   q0;

  logic [7:0]   d1;
  logic [0:0]   s1;
  logic         v1, r1, rdy1, ov1;
  logic [7:0]   q1;

  logic [127:0] d2;
  logic [3:0]   s2;
  logic         v2, r2, rdy2, ov2;
  logic [7:0]   q2;

`ifdef MUX_N_PIPE_SELCHK_EN
  logic e0, e1, e2;
`endif

  mux_n_pipe #(.N(9), .W(8), .M(4), .STAGES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(d0), .in_sel(s0), .in_valid(v0),
    .in_ready(rdy0), .out_data(q0), .out_valid(ov0),
`ifdef MUX_N_PIPE_SELCHK_EN
    .sel_err(e0),
`endif
    .out_ready(r0)
  );

  mux_n_pipe #(.N(1), .W(8), .M(1), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1), .in_sel(s1), .in_valid(v1),
    .in_ready(rdy1), .out_data(q1), .out_valid(ov1),
`ifdef MUX_N_PIPE_SELCHK_EN
    .sel_err(e1),
`endif
    .out_ready(r1)
  );

  mux_n_pipe #(.N(16), .W(8), .M(4), .STAGES(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2), .in_sel(s2), .in_valid(v2),
    .in_ready(rdy2), .out_data(q2), .out_valid(ov2),
`ifdef MUX_N_PIPE_SELCHK_EN
    .sel_err(e2),
`endif
    .out_ready(r2)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 9; i++) d0[i*8 +: 8] = 8'(8'h10 + i);
    for (int i = 0; i < 16; i++) d2[i*8 +: 8] = 8'(8'h80 + i);
    d1 = 8'h3C;
    s0 = '0; s1 = '0; s2 = '0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;

    // Reset state
    tick; tick;
    chk("rst_ov0", ov0, 0);
    chk("rst_q0", q0, 0);
    chk("rst_ov1", ov1, 0);
    chk("rst_ov2", ov2, 0);
    rst_n = 1'b1;
    #1;
    chk("rdy_after_rst", rdy0, 1);

    // Streaming sel 0..8, latency 2, no gaps
    for (int i = 0; i < 11; i++) begin
      v0 = (i < 9);
      s0 = (i < 9) ? 4'(i) : 4'd0;
      #1;
      chk($sformatf("stream_rdy%0d", i), rdy0, 1);
      tick;
      if (i >= 1 && i <= 9) begin
        chk($sformatf("stream_ov%0d", i), ov0, 1);
        chk($sformatf("stream_q%0d", i), q0, 32'(8'h10 + i - 1));
      end else begin
        chk($sformatf("stream_ov%0d", i), ov0, 0);
      end
    end

    // Out-of-range select in the middle of a stream
    v0 = 1'b1; s0 = 4'd2;  tick;
    chk("oor_ov_a", ov0, 0);
    s0 = 4'd12;            tick;
    chk("oor_q_b", q0, 8'h12);
`ifdef MUX_N_PIPE_SELCHK_EN
    chk("oor_err_b", e0, 0);
`endif
    s0 = 4'd4;             tick;
    chk("oor_ov_c", ov0, 1);
    chk("oor_q_c", q0, 8'h00);
`ifdef MUX_N_PIPE_SELCHK_EN
    chk("oor_err_c", e0, 1);
`endif
    v0 = 1'b0;             tick;
    chk("oor_q_d", q0, 8'h14);
`ifdef MUX_N_PIPE_SELCHK_EN
    chk("oor_err_d", e0, 0);
`endif
    tick;
    chk("oor_ov_e", ov0, 0);

    // Stall for 5 cycles starting from an empty pipeline
    r0 = 1'b0; v0 = 1'b1; s0 = 4'd5; #1;
    chk("stall_rdy0", rdy0, 1);
    tick;
    chk("stall_ov0", ov0, 0);
    s0 = 4'd6; #1;
    chk("stall_rdy1", rdy0, 1);
    tick;
    chk("stall_q1", q0, 8'h15);
    s0 = 4'd7;
    for (int i = 2; i < 5; i++) begin
      #1;
      chk($sformatf("stall_rdy%0d", i), rdy0, 0);
      tick;
      chk($sformatf("stall_ov%0d", i), ov0, 1);
      chk($sformatf("stall_q%0d", i), q0, 8'h15);
    end
    r0 = 1'b1; #1;
    chk("stall_rdy5", rdy0, 1);
    tick;
    chk("stall_q5", q0, 8'h16);
    v0 = 1'b0; tick;
    chk("stall_q6", q0, 8'h17);
    tick;
    chk("stall_ov7", ov0, 0);

    // Bubble collapse: output held, stage 0 empty, next beat still accepted
    v0 = 1'b1; s0 = 4'd8; tick;
    v0 = 1'b0;            tick;
    chk("bub_q_hold", q0, 8'h18);
    r0 = 1'b0; v0 = 1'b1; s0 = 4'd0; #1;
    chk("bub_rdy", rdy0, 1);
    tick;
    chk("bub_q_stall", q0, 8'h18);
    v0 = 1'b0; #1;
    chk("bub_rdy_full", rdy0, 0);
    tick;
    chk("bub_ov_stall", ov0, 1);
    r0 = 1'b1; tick;
    chk("bub_q_next", q0, 8'h10);
    tick;
    chk("bub_ov_end", ov0, 0);

    // Asynchronous reset with two beats in flight
    v0 = 1'b1; s0 = 4'd1; tick;
    s0 = 4'd2;            tick;
    chk("ar_q_before", q0, 8'h11);
    v0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ov_async", ov0, 0);
    chk("ar_q_async", q0, 0);
    tick;
    rst_n = 1'b1;
    d0[3*8 +: 8] = 8'hA5;
    v0 = 1'b1; s0 = 4'd3; #1;
    chk("ar_rdy", rdy0, 1);
    tick;
    chk("ar_ov_flushed", ov0, 0);
    v0 = 1'b0; tick;
    chk("ar_ov_new", ov0, 1);
    chk("ar_q_new", q0, 8'hA5);
    tick;
    chk("ar_ov_end", ov0, 0);

    // N=1, STAGES=1: select ignored, latency 1
    v1 = 1'b1; s1 = 1'b1; #1;
    chk("n1_rdy", rdy1, 1);
    tick;
    chk("n1_ov_a", ov1, 1);
    chk("n1_q_a", q1, 8'h3C);
    d1 = 8'h5A; s1 = 1'b0; tick;
    chk("n1_q_b", q1, 8'h5A);
    v1 = 1'b0; tick;
    chk("n1_ov_end", ov1, 0);

    // N=16, STAGES=4: sel 15 -> lane 15 after 4 cycles
    v2 = 1'b1; s2 = 4'd15; tick;
    v2 = 1'b0;
    chk("n16_ov1", ov2, 0);
    tick;
    chk("n16_ov2", ov2, 0);
    tick;
    chk("n16_ov3", ov2, 0);
    tick;
    chk("n16_ov4", ov2, 1);
    chk("n16_q4", q2, 8'h8F);
    tick;
    chk("n16_ov5", ov2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
